button_event_scanner: RTL

- Debounces N_BTN pushbuttons with one shared tick prescaler and one time-multiplexed scan FSM, instead of one wide counter per button.
- Turns each debounced transition into a press, release or long-press event.
- Queues events in a small FIFO read by a valid/ready consumer, such as the game or menu FSM above the board I/O layer.

---
 rtl/button_event_scanner.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_scanner.sv
// button_event_scanner
//   Debounces N_BTN pushbuttons using one shared tick prescaler and a single
//   time-multiplexed scan FSM. Each debounced transition becomes a press,
//   release or long-press event, queued in a small FIFO that a valid/ready
//   consumer drains.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   noisy      raw button levels (async, 1 = pressed)
//   clean      debounced button levels
//   ev_valid   FIFO head is valid
//   ev_ready   consumer accepts the head this cycle
//   ev_code    01 press, 10 release, 11 long-press, 00 when ev_valid=0
//   ev_btn     button index of the head event (0 when ev_valid=0)
//   overflow   sticky flag: an event was dropped because the FIFO was full
//   clear_ovf  synchronous clear of overflow (a simultaneous drop wins)
module button_event_scanner #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned FIFO_DEPTH   = 4,
    localparam int unsigned BW          = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] noisy,
    output logic [N_BTN-1:0] clean,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_code,
    output logic [BW-1:0]    ev_btn,
    output logic             overflow,
    input  logic             clear_ovf
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HW = $clog2(LONG_TICKS + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        EV_NONE    = 2'b00,
        EV_PRESS   = 2'b01,
        EV_RELEASE = 2'b10,
        EV_LONG    = 2'b11
    } ev_code_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        ev_code_t       code;
        logic [BW-1:0]  btn;
    } entry_t;

    // ------------------------------------------------------------------
    // Two-flop input synchronizer
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_lvl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_lvl  <= '0;
        end else begin
            sync_meta <= noisy;
            sync_lvl  <= sync_meta;
        end
    end

    // ------------------------------------------------------------------
    // Shared scan-tick prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM: one button serviced per cycle after each tick
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [BW-1:0] idx, idx_nxt;
    logic          last_btn;
    logic          service;

    assign last_btn = (idx == BW'(N_BTN - 1));
    assign service  = (state == SCAN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (last_btn) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + BW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-button service of button idx
    // ------------------------------------------------------------------
    logic [SW-1:0] stab [N_BTN];
    logic [HW-1:0] hold [N_BTN];

    logic          cur_clean;
    logic          cur_sync;
    logic [SW-1:0] stab_inc;
    logic [SW-1:0] stab_nxt;
    logic [HW-1:0] hold_inc;
    logic [HW-1:0] hold_nxt;
    logic          clean_nxt;
    logic          push;
    ev_code_t      push_code;

    always_comb begin
        cur_clean = clean[idx];
        cur_sync  = sync_lvl[idx];
        stab_inc  = stab[idx] + SW'(1);
        hold_inc  = hold[idx] + HW'(1);
        stab_nxt  = stab[idx];
        hold_nxt  = hold[idx];
        clean_nxt = cur_clean;
        push      = 1'b0;
        push_code = EV_NONE;

        // Debounce: count consecutive differing samples
        if (cur_sync == cur_clean) begin
            stab_nxt = '0;
        end else if (stab_inc == SW'(STABLE_TICKS)) begin
            stab_nxt  = '0;
            clean_nxt = ~cur_clean;
            push      = 1'b1;
            push_code = cur_clean ? EV_RELEASE : EV_PRESS;
        end else begin
            stab_nxt = stab_inc;
        end

        // Long-press: counting starts on the service after the press, so
        // a press/release and a long-press never share one service.
        if (!cur_clean || !clean_nxt) begin
            hold_nxt = '0;
        end else if (hold[idx] != HW'(LONG_TICKS)) begin
            hold_nxt = hold_inc;
            if (hold_inc == HW'(LONG_TICKS)) begin
                push      = 1'b1;
                push_code = EV_LONG;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clean <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                stab[i] <= '0;
                hold[i] <= '0;
            end
        end else if (service) begin
            clean[idx] <= clean_nxt;
            stab[idx]  <= stab_nxt;
            hold[idx]  <= hold_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (registered, no fall-through)
    // ------------------------------------------------------------------
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic          drop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = ev_valid && ev_ready;
    assign push_req = service && push;
    // A pop in the same cycle frees the slot the push is written into
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= '{code: push_code, btn: idx};
        end
    end

    assign head     = mem[rd_ptr[AW-1:0]];
    assign ev_valid = !empty;
    assign ev_code  = ev_valid ? head.code : EV_NONE;
    assign ev_btn   = ev_valid ? head.btn  : '0;

    // ------------------------------------------------------------------
    // Sticky overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
